unidade_busca: RTL and testbench



---
 rtl/cpu_pkg.sv | 30 +++
 rtl/proximo_pc.sv | 45 ++++
 rtl/unidade_busca.sv | 104 ++++++++++
 tb/tb_unidade_busca.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, next-PC source encodings,
// fetch FSM state encodings and instruction-register field positions.
package cpu_pkg;

  localparam logic [3:0] OP_JUMP = 4'd11;
  localparam logic [3:0] OP_BEQ  = 4'd12;

  localparam logic [1:0] FCP_SEQ    = 2'b00;
  localparam logic [1:0] FCP_BRANCH = 2'b01;
  localparam logic [1:0] FCP_JUMP   = 2'b10;

  typedef logic [1:0] estado_t;

  localparam estado_t INICIO     = 2'd0;
  localparam estado_t BUSCA      = 2'd1;
  localparam estado_t DECODIFICA = 2'd2;
  localparam estado_t EXECUTA    = 2'd3;

  localparam int IR_OP_HI  = 15;
  localparam int IR_OP_LO  = 12;
  localparam int IR_RD_HI  = 11;
  localparam int IR_RD_LO  = 8;
  localparam int IR_RS_HI  = 7;
  localparam int IR_RS_LO  = 4;
  localparam int IR_RT_HI  = 3;
  localparam int IR_RT_LO  = 0;
  localparam int IR_IMM_HI = 7;
  localparam int IR_IMM_LO = 0;

endpackage

// File: rtl/proximo_pc.sv
// Next-PC selection: sequential, relative branch, absolute jump or hold,
// gated by the unconditional and conditional PC write enables.
module proximo_pc
  import cpu_pkg::*;
#(
  parameter int WIDTH_PC = 8
) (
  input  logic [WIDTH_PC-1:0] i_pc,
  input  logic [7:0]          i_imm,
  input  logic [1:0]          i_fonte_cp,
  input  logic                i_esc_cp,
  input  logic                i_esc_cond_cp,
  input  logic                i_zero,
  output logic [WIDTH_PC-1:0] o_prox_pc
);

  logic [WIDTH_PC-1:0] w_pc1;
  logic [WIDTH_PC-1:0] w_sext;
  logic [WIDTH_PC-1:0] w_zext;
  logic [WIDTH_PC-1:0] w_tgt;

  assign w_pc1  = i_pc + WIDTH_PC'(1);
  assign w_sext = WIDTH_PC'($signed(i_imm));
  assign w_zext = WIDTH_PC'(i_imm);

  always_comb begin
    w_tgt = i_pc;
    case (i_fonte_cp)
      FCP_SEQ:    w_tgt = w_pc1;
      FCP_BRANCH: w_tgt = w_pc1 + w_sext;
      FCP_JUMP:   w_tgt = w_zext;
      default:    w_tgt = i_pc;
    endcase
  end

  // A not-taken conditional branch always falls through, whatever the source.
  always_comb begin
    o_prox_pc = i_pc;
    if (i_esc_cond_cp)
      o_prox_pc = i_zero ? w_tgt : w_pc1;
    else if (i_esc_cp)
      o_prox_pc = w_tgt;
  end

endmodule

// File: rtl/unidade_busca.sv
// Fetch/decode unit: owns PC and IR, fetches over req/ack, applies next-PC.
// Optional PERF_CNT_EN adds retired-instruction and fetch-wait counters.
module unidade_busca
  import cpu_pkg::*;
#(
  parameter int                  WIDTH_PC    = 8,
  parameter int                  WIDTH_INSTR = 16,
  parameter logic [WIDTH_PC-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [WIDTH_PC-1:0]    mem_addr,
  input  logic                   mem_ack,
  input  logic [WIDTH_INSTR-1:0] mem_data,
  input  logic                   EscCP,
  input  logic                   EscCondCP,
  input  logic [1:0]             FonteCP,
  input  logic                   zero,
  output logic [3:0]             opcode,
  output logic [3:0]             rd,
  output logic [3:0]             rs,
  output logic [3:0]             rt,
  output logic [7:0]             imm,
  output logic [WIDTH_PC-1:0]    pc,
`ifdef PERF_CNT_EN
  output logic [31:0]            ret_count,
  output logic [15:0]            fetch_wait,
`endif
  output logic                   instr_valid
);

  estado_t                r_estado;
  logic [WIDTH_PC-1:0]    r_pc;
  logic [WIDTH_INSTR-1:0] r_ir;
  logic [WIDTH_PC-1:0]    w_prox_pc;

  assign opcode      = r_ir[IR_OP_HI:IR_OP_LO];
  assign rd          = r_ir[IR_RD_HI:IR_RD_LO];
  assign rs          = r_ir[IR_RS_HI:IR_RS_LO];
  assign rt          = r_ir[IR_RT_HI:IR_RT_LO];
  assign imm         = r_ir[IR_IMM_HI:IR_IMM_LO];
  assign pc          = r_pc;
  assign mem_req     = (r_estado == BUSCA);
  assign mem_addr    = r_pc;
  assign instr_valid = (r_estado == DECODIFICA) ||
                       (r_estado == EXECUTA);

  proximo_pc #(
    .WIDTH_PC(WIDTH_PC)
  ) u_proximo_pc (
    .i_pc         (r_pc),
    .i_imm        (imm),
    .i_fonte_cp   (FonteCP),
    .i_esc_cp     (EscCP),
    .i_esc_cond_cp(EscCondCP),
    .i_zero       (zero),
    .o_prox_pc    (w_prox_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= INICIO;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
    end else begin
      case (r_estado)
        INICIO: r_estado <= BUSCA;
        BUSCA: begin
          if (mem_ack) begin
            r_ir     <= mem_data;
            r_estado <= DECODIFICA;
          end
        end
        DECODIFICA: r_estado <= EXECUTA;
        default: begin
          r_pc     <= w_prox_pc;
          r_estado <= BUSCA;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] r_ret_count;
  logic [15:0] r_fetch_wait;

  assign ret_count  = r_ret_count;
  assign fetch_wait = r_fetch_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ret_count  <= '0;
      r_fetch_wait <= '0;
    end else begin
      if (r_estado == EXECUTA)
        r_ret_count <= r_ret_count + 32'd1;
      if (mem_req && !mem_ack && r_fetch_wait != 16'hFFFF)
        r_fetch_wait <= r_fetch_wait + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unidade_busca.sv
// Directed bench for unidade_busca: a fetch-address scoreboard queue
// plus a small next-PC model checked with immediate assertions.
module tb_unidade_busca;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = '0;
  logic        EscCP = 1'b0;
  logic        EscCondCP = 1'b0;
  logic [1:0]  FonteCP = 2'b00;
  logic        zero = 1'b0;
  logic [3:0]  opcode, rd, rs, rt;
  logic [7:0]  imm;
  logic [7:0]  pc;
  logic        instr_valid;
`ifdef PERF_CNT_EN
  logic [31:0] ret_count;
  logic [15:0] fetch_wait;
`endif

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;
  int unsigned ret_exp = 0;
  int unsigned wait_exp = 0;
  logic [7:0]  q_addr[$];

  always #5 clk = ~clk;

  unidade_busca dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .EscCP      (EscCP),
    .EscCondCP  (EscCondCP),
    .FonteCP    (FonteCP),
    .zero       (zero),
    .opcode     (opcode),
    .rd         (rd),
    .rs         (rs),
    .rt         (rt),
    .imm        (imm),
    .pc         (pc),
`ifdef PERF_CNT_EN
    .ret_count  (ret_count),
    .fetch_wait (fetch_wait),
`endif
    .instr_valid(instr_valid)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model(input logic [7:0] p,
                                       input logic [7:0] im,
                                       input logic [1:0] f,
                                       input logic e,
                                       input logic ec,
                                       input logic z);
    logic [7:0] p1, t;
    p1 = p + 8'd1;
    if (f == 2'b00)      t = p1;
    else if (f == 2'b01) t = p1 + im;
    else if (f == 2'b10) t = im;
    else                 t = p;
    if (ec)     return z ? t : p1;
    else if (e) return t;
    return p;
  endfunction

  // Entered at a negedge inside the first BUSCA cycle.
  task automatic do_instr(input logic [15:0] d, input int lat,
                          input logic e, input logic ec,
                          input logic [1:0] f, input logic z);
    logic [7:0] a;
    a = q_addr.pop_front();
    chk("req_first", {31'd0, mem_req}, 32'd1);
    chk("addr_first", {24'd0, mem_addr}, {24'd0, a});
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("req_hold", {31'd0, mem_req}, 32'd1);
      chk("addr_hold", {24'd0, mem_addr}, {24'd0, a});
    end
    wait_exp += lat;
    mem_ack  = 1'b1;
    mem_data = d;
    @(negedge clk);
    mem_ack  = 1'b0;
    mem_data = 16'hDEAD;
    chk("dec_valid", {31'd0, instr_valid}, 32'd1);
    chk("dec_req", {31'd0, mem_req}, 32'd0);
    chk("opcode", {28'd0, opcode}, {28'd0, d[15:12]});
    chk("rd", {28'd0, rd}, {28'd0, d[11:8]});
    chk("rs", {28'd0, rs}, {28'd0, d[7:4]});
    chk("rt", {28'd0, rt}, {28'd0, d[3:0]});
    chk("imm", {24'd0, imm}, {24'd0, d[7:0]});
    chk("pc", {24'd0, pc}, {24'd0, a});
    EscCP = e; EscCondCP = ec; FonteCP = f; zero = z;
    @(negedge clk);
    chk("exe_valid", {31'd0, instr_valid}, 32'd1);
    q_addr.push_back(model(a, d[7:0], f, e, ec, z));
    ret_exp++;
    @(negedge clk);
    EscCP = 1'b0; EscCondCP = 1'b0; FonteCP = 2'b00; zero = 1'b0;
    chk("exe_to_busca", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    // reset two cycles with a stale ack held high
    mem_ack  = 1'b1;
    mem_data = 16'hA5A5;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_opcode", {28'd0, opcode}, 32'd0);
`ifdef PERF_CNT_EN
    chk("rst_ret", ret_count, 32'd0);
    chk("rst_wait", {16'd0, fetch_wait}, 32'd0);
`endif
    rst = 1'b0;
    chk("inicio_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("inicio_ack_ignored", {16'd0, opcode, rd, rs, rt}, 32'd0);
    q_addr.push_back(8'h00);

    do_instr(16'h1234, 2, 1'b1, 1'b0, 2'b00, 1'b0);
    do_instr(16'hB020, 1, 1'b1, 1'b0, 2'b10, 1'b0);
    do_instr(16'hB005, 0, 1'b1, 1'b0, 2'b10, 1'b0);
    do_instr(16'hC0FE, 0, 1'b0, 1'b1, 2'b01, 1'b1);
    do_instr(16'hB005, 3, 1'b1, 1'b0, 2'b10, 1'b0);
    do_instr(16'hC0FE, 0, 1'b0, 1'b1, 2'b01, 1'b0);
    do_instr(16'hB0FF, 1, 1'b1, 1'b0, 2'b10, 1'b0);
    do_instr(16'h0000, 0, 1'b1, 1'b0, 2'b00, 1'b0);
    do_instr(16'hB0FF, 0, 1'b1, 1'b0, 2'b10, 1'b0);
    do_instr(16'h7777, 2, 1'b0, 1'b0, 2'b00, 1'b0);
    do_instr(16'h8888, 0, 1'b1, 1'b0, 2'b11, 1'b0);

    // reset while requesting, with an ack landing on the reset edge
    chk("pre_rst_addr", {24'd0, mem_addr}, {24'd0, q_addr.pop_front()});
    rst      = 1'b1;
    mem_ack  = 1'b1;
    mem_data = 16'hFFFF;
    @(negedge clk);
    chk("mid_rst_ir", {16'd0, opcode, rd, rs, rt}, 32'd0);
    chk("mid_rst_pc", {24'd0, pc}, 32'd0);
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    rst     = 1'b0;
    mem_ack = 1'b0;
    ret_exp  = 0;
    wait_exp = 0;
    chk("mid_inicio_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    q_addr.push_back(8'h00);
    do_instr(16'h1234, 2, 1'b1, 1'b0, 2'b00, 1'b0);
    do_instr(16'h2345, 2, 1'b1, 1'b0, 2'b00, 1'b0);
    do_instr(16'h3456, 2, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("final_req", {31'd0, mem_req}, 32'd1);
    chk("final_addr", {24'd0, mem_addr}, {24'd0, q_addr.pop_front()});
`ifdef PERF_CNT_EN
    chk("ret_count", ret_count, ret_exp);
    chk("fetch_wait", {16'd0, fetch_wait}, wait_exp);
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
